// File: rtl/wb_bus_ctrl.sv
// Wishbone shared-bus controller. Round-robin arbitration on CYC, a grant
// that is held for the whole bus cycle, top-nibble slave decode, response
// routing back to the owner, and ERR termination of stalled or unmapped
// strobes.
module wb_bus_ctrl #(
    parameter int MASTERS    = 2,
    parameter int SLAVES     = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MASTERS-1:0]            m_cyc,
    input  logic [MASTERS-1:0]            m_stb,
    input  logic [MASTERS*ADDR_WIDTH-1:0] m_adr,
    output logic [MASTERS-1:0]            grant,
    output logic                          grant_valid,
    output logic [SLAVES-1:0]             s_stb,
    input  logic [SLAVES-1:0]             s_ack,
    input  logic [SLAVES-1:0]             s_err,
    input  logic [SLAVES-1:0]             s_rty,
    output logic [MASTERS-1:0]            m_ack,
    output logic [MASTERS-1:0]            m_err,
    output logic [MASTERS-1:0]            m_rty
);

    localparam int OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, OWN, ERR} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic [OW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [7:0]      wdog, wdog_nxt;

    // Owner-side view of the bus and the decoded slave
    logic [MASTERS-1:0] owner_onehot;
    logic               owner_cyc;
    logic               owner_stb;
    logic [3:0]         idx;
    logic               miss;
    logic [SLAVES-1:0]  slave_hit;
    logic               sel_ack, sel_err, sel_rty;
    logic               strobe_ok;
    logic               resp_any;
    int                 best_dist;

    // Only the top nibble selects a slave; the rest of the address is for the slaves.
    logic unused_adr_bits;
    assign unused_adr_bits = ^m_adr;

    // Distance of master m from the round-robin pointer, counting upward with wrap.
    function automatic int rr_dist(input int m, input logic [OW-1:0] ptr);
        int d;
        d = m - int'(ptr);
        if (d < 0) d = d + MASTERS;
        return d;
    endfunction

    // Pointer value that follows the current owner, wrapping at MASTERS.
    function automatic logic [OW-1:0] after_owner(input logic [OW-1:0] g);
        return (g == OW'(MASTERS - 1)) ? '0 : g + OW'(1);
    endfunction

    // Select the owner's CYC/STB/address nibble and the addressed slave's responses.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        owner_onehot = '0;
        owner_cyc    = 1'b0;
        owner_stb    = 1'b0;
        idx          = '0;
        for (int m = 0; m < MASTERS; m++) begin
            if (owner == OW'(m)) begin
                owner_onehot[m] = 1'b1;
                owner_cyc       = m_cyc[m];
                owner_stb       = m_stb[m];
                idx             = m_adr[m*ADDR_WIDTH + ADDR_WIDTH - 4 +: 4];
            end
        end
        miss      = ({1'b0, idx} >= 5'(SLAVES));
        slave_hit = '0;
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        sel_rty   = 1'b0;
        for (int s = 0; s < SLAVES; s++) begin
            if (idx == 4'(s)) begin
                slave_hit[s] = 1'b1;
                sel_ack      = s_ack[s];
                sel_err      = s_err[s];
                sel_rty      = s_rty[s];
            end
        end
        strobe_ok = owner_stb & ~miss;
        resp_any  = sel_ack | sel_err | sel_rty;
    end

    // Next-state, arbitration, watchdog and output decode.
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        wdog_nxt    = '0;
        best_dist   = MASTERS;
        grant       = '0;
        grant_valid = 1'b0;
        s_stb       = '0;
        m_ack       = '0;
        m_err       = '0;
        m_rty       = '0;
        case (state)
            IDLE: begin
                // Requester closest to rr_ptr (upward, wrapping) wins.
                for (int m = 0; m < MASTERS; m++) begin
                    if (m_cyc[m] && (rr_dist(m, rr_ptr) < best_dist)) begin
                        best_dist = rr_dist(m, rr_ptr);
                        owner_nxt = OW'(m);
                    end
                end
                if (best_dist < MASTERS) state_nxt = OWN;
            end
            OWN: begin
                grant       = owner_onehot;
                grant_valid = 1'b1;
                if (strobe_ok) begin
                    s_stb = slave_hit;
                    m_ack = owner_onehot & {MASTERS{sel_ack}};
                    m_err = owner_onehot & {MASTERS{sel_err}};
                    m_rty = owner_onehot & {MASTERS{sel_rty}};
                end
                if (!owner_cyc) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = after_owner(owner);
                end else if (owner_stb && miss) begin
                    state_nxt = ERR;
                end else if (strobe_ok && !resp_any) begin
                    if (wdog == 8'(TIMEOUT - 1)) state_nxt = ERR;
                    else                         wdog_nxt  = wdog + 8'd1;
                end
            end
            ERR: begin
                grant       = owner_onehot;
                grant_valid = 1'b1;
                m_err       = owner_onehot;
                if (owner_cyc) begin
                    state_nxt = OWN;
                end else begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = after_owner(owner);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, owner, round-robin pointer and watchdog registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            wdog   <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            wdog   <= wdog_nxt;
        end
    end

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// Bench for wb_bus_ctrl: directed scenarios with literal expectations plus a
// transaction-level bus model compared against every output on every cycle.
module tb_wb_bus_ctrl;

    localparam int M  = 2;
    localparam int S  = 4;
    localparam int AW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    m_cyc, m_stb;
    logic [M*AW-1:0] m_adr;
    logic [M-1:0]    grant;
    logic            grant_valid;
    logic [S-1:0]    s_stb;
    logic [S-1:0]    s_ack, s_err, s_rty;
    logic [M-1:0]    m_ack, m_err, m_rty;

    wb_bus_ctrl #(
        .MASTERS   (M),
        .SLAVES    (S),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_cyc      (m_cyc),
        .m_stb      (m_stb),
        .m_adr      (m_adr),
        .grant      (grant),
        .grant_valid(grant_valid),
        .s_stb      (s_stb),
        .s_ack      (s_ack),
        .s_err      (s_err),
        .s_rty      (s_rty),
        .m_ack      (m_ack),
        .m_err      (m_err),
        .m_rty      (m_rty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who holds the bus, the pending one-cycle error, and how many
    // consecutive strobe cycles have gone unanswered.
    bit mdl_valid = 1'b0;
    bit busy      = 1'b0;
    bit err_now   = 1'b0;
    int own       = 0;
    int rr        = 0;
    int waited    = 0;

    logic [M-1:0] e_grant, e_ack, e_err, e_rty;
    logic         e_gv;
    logic [S-1:0] e_stb;
    int           e_idx;
    bit           stb_on, hit, resp, picked;

    // Compare all outputs against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        e_grant = '0; e_gv = 1'b0; e_stb = '0; e_ack = '0; e_err = '0; e_rty = '0;
        e_idx = 0; stb_on = 1'b0; hit = 1'b0; resp = 1'b0;
        if (busy) begin
            e_grant[own] = 1'b1;
            e_gv         = 1'b1;
            if (err_now) begin
                e_err[own] = 1'b1;
            end else begin
                e_idx  = int'(m_adr[own*AW + AW - 4 +: 4]);
                hit    = (e_idx < S);
                stb_on = m_stb[own];
                if (stb_on && hit) begin
                    e_stb[e_idx] = 1'b1;
                    e_ack[own]   = s_ack[e_idx];
                    e_err[own]   = s_err[e_idx];
                    e_rty[own]   = s_rty[e_idx];
                    resp         = s_ack[e_idx] | s_err[e_idx] | s_rty[e_idx];
                end
            end
        end
        if (mdl_valid)
            check("bus_outputs", 32'({grant, grant_valid, s_stb, m_ack, m_err, m_rty}),
                  32'({e_grant, e_gv, e_stb, e_ack, e_err, e_rty}));

        if (rst) begin
            busy = 1'b0; err_now = 1'b0; rr = 0; waited = 0;
            mdl_valid = 1'b1;
        end else if (!busy) begin
            picked = 1'b0;
            for (int k = 0; k < M; k++) begin
                if (!picked && m_cyc[(rr + k) % M]) begin
                    own = (rr + k) % M; picked = 1'b1;
                end
            end
            busy = picked;
        end else if (err_now) begin
            err_now = 1'b0;
            if (!m_cyc[own]) begin busy = 1'b0; rr = (own + 1) % M; end
        end else if (!m_cyc[own]) begin
            busy = 1'b0; rr = (own + 1) % M; waited = 0;
        end else if (stb_on && !hit) begin
            err_now = 1'b1; waited = 0;
        end else if (stb_on && !resp) begin
            waited++;
            if (waited == TO) begin err_now = 1'b1; waited = 0; end
        end else begin
            waited = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [M*AW-1:0] adr2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        return {a1, a0};
    endfunction

    task automatic clear_inputs();
        m_cyc = '0; m_stb = '0; m_adr = '0;
        s_ack = '0; s_err = '0; s_rty = '0;
    endtask

    // Two reset cycles; leaves rst low going into cycle 0.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_valid", 32'(grant_valid), 32'h0);
        check("rst_resp", 32'({s_stb, m_ack, m_err, m_rty}), 32'h0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_stb", 32'(s_stb), 32'h0);

        // Arbitration latency and ack routing
        rst = 1'b0; m_cyc = 2'b01;                                  // c0
        step(); check("arb_grant", 32'(grant), 32'h1);              // c1
        check("arb_valid", 32'(grant_valid), 32'h1);
        step(); m_stb = 2'b01; m_adr = adr2(32'h2000_0000, '0);     // c2
        #1 check("stb_slave2", 32'(s_stb), 32'h4);
        step(); s_ack = 4'b0100;                                    // c3
        #1 check("ack_stb", 32'(s_stb), 32'h4);
        check("ack_route", 32'(m_ack), 32'h1);
        step(); s_ack = '0; m_stb = '0;                             // c4
        step(); m_cyc = '0;                                         // c5
        step(); check("release_idle", 32'(grant_valid), 32'h0);    // c6

        // Round-robin handover, no preemption, RTY routing, foreign responses
        do_reset();
        m_cyc = 2'b11;                                              // c0
        step(); check("rr_first", 32'(grant), 32'h1);               // c1
        step(); step(); step();                                     // c2..c4
        step(); m_cyc = 2'b10;                                      // c5
        #1 check("rr_hold", 32'(grant), 32'h1);
        step(); check("rr_gap_grant", 32'(grant), 32'h0);           // c6
        check("rr_gap_valid", 32'(grant_valid), 32'h0);
        step(); check("rr_second", 32'(grant), 32'h2);              // c7
        step(); m_cyc = 2'b11;                                      // c8
        step(); check("no_preempt", 32'(grant), 32'h2);             // c9
        m_stb = 2'b10; m_adr = adr2('0, 32'h3000_0000); s_rty = 4'b1000;
        #1 check("rty_stb", 32'(s_stb), 32'h8);
        check("rty_route", 32'(m_rty), 32'h2);
        step(); s_rty = '0; s_ack = 4'b0001;                        // c10
        #1 check("foreign_ack", 32'(m_ack), 32'h0);
        step(); s_ack = '0; m_stb = '0; m_cyc = 2'b01;              // c11
        step(); check("rr_gap2", 32'(grant_valid), 32'h0);          // c12
        step(); check("rr_wrap", 32'(grant), 32'h1);                // c13

        // Watchdog expiry
        do_reset();
        m_cyc = 2'b01;                                              // c0
        step();                                                     // c1
        step(); m_stb = 2'b01; m_adr = adr2(32'h1000_0000, '0);     // c2
        #1 check("wd_stb", 32'(s_stb), 32'h2);
        step(); step(); step();                                     // c3..c5
        check("wd_last_stb", 32'(s_stb), 32'h2);
        check("wd_no_err_yet", 32'(m_err), 32'h0);
        step(); check("wd_err", 32'(m_err), 32'h1);                 // c6
        check("wd_err_stb", 32'(s_stb), 32'h0);
        step(); m_stb = '0;                                         // c7
        #1 check("wd_err_once", 32'(m_err), 32'h0);
        check("wd_still_own", 32'(grant), 32'h1);

        // Decode miss, then a miss whose owner drops CYC during ERR
        step(); m_stb = 2'b01; m_adr = adr2(32'hF000_0000, '0);     // c8
        #1 check("miss_no_stb", 32'(s_stb), 32'h0);
        check("miss_no_err_yet", 32'(m_err), 32'h0);
        step(); m_stb = '0;                                         // c9
        #1 check("miss_err", 32'(m_err), 32'h1);
        step(); check("miss_back_own", 32'(grant_valid), 32'h1);    // c10
        check("miss_err_once", 32'(m_err), 32'h0);
        step(); m_stb = 2'b01;                                      // c11
        step(); m_stb = '0; m_cyc = '0;                             // c12
        #1 check("err_completes", 32'(m_err), 32'h1);
        step(); check("err_to_idle", 32'(grant_valid), 32'h0);      // c13

        // Response on the expiry cycle wins and restarts the watchdog
        do_reset();
        m_cyc = 2'b01;                                              // c0
        step();                                                     // c1
        step(); m_stb = 2'b01; m_adr = adr2(32'h0000_0000, '0);     // c2
        step(); step();                                             // c3..c4
        step(); s_ack = 4'b0001;                                    // c5
        #1 check("exp_ack", 32'(m_ack), 32'h1);
        check("exp_no_err", 32'(m_err), 32'h0);
        step(); s_ack = '0;                                         // c6
        step(); step(); step();                                     // c7..c9
        check("wd_restart_quiet", 32'(m_err), 32'h0);
        step(); check("wd_restart_err", 32'(m_err), 32'h1);         // c10
        step(); s_err = 4'b0001;                                    // c11
        #1 check("slave_err_route", 32'(m_err), 32'h1);
        step(); s_err = '0; m_stb = '0; m_cyc = '0;                 // c12
        step();                                                     // c13

        // Reset in the middle of master 1's strobe
        m_cyc = 2'b11;
        step(); check("m1_owner", 32'(grant), 32'h2);               // c14
        step(); m_stb = 2'b10; m_adr = adr2('0, 32'h2000_0000);     // c15
        #1 check("m1_stb", 32'(s_stb), 32'h4);
        step(); rst = 1'b1;                                         // c16
        #1 check("rst_sync", 32'(s_stb), 32'h4);
        step(); check("midrst_grant", 32'(grant), 32'h0);           // c17
        check("midrst_valid", 32'(grant_valid), 32'h0);
        check("midrst_stb", 32'(s_stb), 32'h0);
        rst = 1'b0;
        step(); check("post_rst_m0", 32'(grant), 32'h1);            // c18

        clear_inputs();
        step(); step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
